// File: rtl/fcfs_arb_pkg.sv
// Shared helpers for the FCFS arbiter family.
package fcfs_arb_pkg;

    // $clog2 that never returns 0, so a 1-value range still gets a 1-bit vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rr_order_enc.sv
// Orders a set of simultaneous arrivals round-robin starting at i_ptr and
// emits them as a packed ID list (slot 0 first) plus a count.
module rr_order_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]           i_mask,
    input  logic [ID_W-1:0]        i_ptr,
    output logic [ID_W:0]          o_cnt,
    output logic [N-1:0][ID_W-1:0] o_ids
);
    localparam int CNT_W = ID_W + 1;

    always_comb begin
        int n;
        int idx;
        n     = 0;
        idx   = 0;
        o_ids = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (i_mask[idx]) begin
                o_ids[n] = ID_W'(idx);
                n++;
            end
        end
        o_cnt = CNT_W'(n);
    end

endmodule

// File: rtl/fcfs_rr_arbiter.sv
// First-come-first-served arbiter: ordered wait queue, round-robin tie-break for
// simultaneous arrivals, withdrawal, optional hold limit with preemption.
module fcfs_rr_arbiter
    import fcfs_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int MAX_HOLD    = 0,
    parameter int ID_W        = $clog2(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id,
    output logic [ID_W:0]          queue_count
);
    localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);
    localparam int CNT_W  = ID_W + 1;

    typedef logic [ID_W-1:0] id_t;

    id_t [NUM_CLIENTS-1:0]  r_q;
    logic [CNT_W-1:0]       r_qcnt;
    logic [NUM_CLIENTS-1:0] r_grant;
    logic                   r_gv;
    id_t                    r_gid;
    id_t                    r_rr;
    logic [HOLD_W-1:0]      r_hold;

    logic [NUM_CLIENTS-1:0] w_pend, w_arr, w_ngrant;
    id_t [NUM_CLIENTS-1:0]  w_aids, w_eq, w_nq;
    logic [CNT_W-1:0]       w_acnt, w_nqcnt;
    logic                   w_rel, w_pre, w_free, w_new, w_ngv;
    id_t                    w_ngid;
    logic [HOLD_W-1:0]      w_nhold;

    // A client is pending while it sits in a valid queue slot or holds the grant.
    always_comb begin
        w_pend = r_grant;
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (i < int'(r_qcnt)) w_pend[r_q[i]] = 1'b1;
    end

    assign w_arr = req & ~w_pend;

    rr_order_enc #(.N(NUM_CLIENTS), .ID_W(ID_W)) u_enc (
        .i_mask (w_arr),
        .i_ptr  (r_rr),
        .o_cnt  (w_acnt),
        .o_ids  (w_aids)
    );

    always_comb begin
        int n;
        n     = 0;
        w_eq  = '0;
        w_pre = 1'b0;
        w_rel = r_gv && !req[r_gid];
        // Effective queue: survivors (order kept), then this edge's arrivals.
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (i < int'(r_qcnt) && req[r_q[i]]) begin
                w_eq[n] = r_q[i];
                n++;
            end
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (i < int'(w_acnt)) begin
                w_eq[n] = w_aids[i];
                n++;
            end
        if (MAX_HOLD > 0)
            w_pre = r_gv && req[r_gid] && (int'(r_hold) == MAX_HOLD - 1) && (n > 0);
        // Preempted holder goes behind everyone, including fresh arrivals.
        if (w_pre) begin
            w_eq[n] = r_gid;
            n++;
        end

        w_free   = !r_gv || w_rel || w_pre;
        w_new    = 1'b0;
        w_ngv    = r_gv;
        w_ngid   = r_gid;
        w_ngrant = r_grant;
        w_nq     = w_eq;
        w_nqcnt  = CNT_W'(n);
        w_nhold  = r_hold;
        if (w_free) begin
            w_nhold = '0;
            if (n > 0) begin
                w_new    = 1'b1;
                w_ngv    = 1'b1;
                w_ngid   = w_eq[0];
                w_ngrant = NUM_CLIENTS'(1) << w_eq[0];
                for (int i = 0; i < NUM_CLIENTS - 1; i++) w_nq[i] = w_eq[i+1];
                w_nq[NUM_CLIENTS-1] = '0;
                w_nqcnt  = CNT_W'(n - 1);
            end else begin
                w_ngv    = 1'b0;
                w_ngid   = '0;
                w_ngrant = '0;
            end
        end else if (int'(r_hold) < MAX_HOLD - 1) begin
            w_nhold = r_hold + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_qcnt  <= '0;
            r_grant <= '0;
            r_gv    <= 1'b0;
            r_gid   <= '0;
            r_rr    <= '0;
            r_hold  <= '0;
        end else begin
            r_q     <= w_nq;
            r_qcnt  <= w_nqcnt;
            r_grant <= w_ngrant;
            r_gv    <= w_ngv;
            r_gid   <= w_ngid;
            r_hold  <= w_nhold;
            if (w_new) r_rr <= id_t'((int'(w_ngid) + 1) % NUM_CLIENTS);
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_gv;
    assign grant_id    = r_gid;
    assign queue_count = r_qcnt;

    logic w_uniq_ok, w_hold_ok;
    always_comb begin
        w_uniq_ok = 1'b1;
        w_hold_ok = 1'b1;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (i < int'(r_qcnt) && r_gv && r_q[i] == r_gid) w_hold_ok = 1'b0;
            for (int j = i + 1; j < NUM_CLIENTS; j++)
                if (j < int'(r_qcnt) && r_q[i] == r_q[j]) w_uniq_ok = 1'b0;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_grant));
    a_holder: assert property (@(posedge clk) disable iff (!rst_n) w_hold_ok);
    a_unique: assert property (@(posedge clk) disable iff (!rst_n) w_uniq_ok);

endmodule
